// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- RV32I instruction decode stage with integrated register file.
//
// Purpose
//   Takes one RV32I instruction word (and its PC) per cycle, reads the source
//   registers from a 31 x 32-bit register file (x0 hard-wired to zero), and
//   presents instruction-class flags, operands and an immediate/offset to the
//   execute stage one clock later. The register file is written through a
//   dedicated writeback port fed from the execute stage's result.
//
// Handshake
//   instr_valid qualifies instr/pc_i in the cycle it is high. stall is the
//   downstream back-pressure: while stall=1 every output register holds and
//   instr/instr_valid are ignored (the upstream stage must hold its word).
//   With stall=0, a valid instruction is consumed on the rising edge and its
//   decode appears on the outputs with valid_o=1. With stall=0 and
//   instr_valid=0 a bubble (all outputs 0) is issued. The writeback port is
//   independent of stall and always writes on the edge when wb_en=1.
//
// Ports
//   clk          in   1   clock, rising-edge active
//   reset        in   1   asynchronous, active-high; clears outputs and x1..x31
//   instr        in  32   RV32I instruction word
//   instr_valid  in   1   instr and pc_i are valid this cycle
//   pc_i         in  32   PC of instr
//   stall        in   1   downstream not ready; hold all outputs
//   wb_en        in   1   register-file write enable
//   wb_dest      in   5   register-file write address (x0 writes dropped)
//   wb_data      in  32   register-file write data
//   is_store, is_load, is_branch, is_jump, is_reg, is_alu
//                out  1   instruction class flags
//   operand_a    out 32   first operand (rs1, PC or 0)
//   operand_b    out 32   second operand (rs2, I/U immediate or 0)
//   branch_dest  out 32   branch/jump offset or load/store base offset
//   dest_o       out  5   destination register (0 when none)
//   func3        out  3   funct3 field (0 for LUI/AUIPC)
//   func7        out  1   instr[30] for OP and OP-IMM shifts-right
//   curr_pc      out 32   PC of the decoded instruction
//   valid_o      out  1   outputs carry a decoded instruction
//   illegal      out  1   previous accepted word had an unknown opcode
// ---------------------------------------------------------------------------
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic [31:0] pc_i,
    input  logic        stall,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    output logic        is_store,
    output logic        is_load,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_reg,
    output logic        is_alu,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [31:0] branch_dest,
    output logic [4:0]  dest_o,
    output logic [2:0]  func3,
    output logic        func7,
    output logic [31:0] curr_pc,
    output logic        valid_o,
    output logic        illegal
);

    // RV32I major opcodes handled by this stage.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // -----------------------------------------------------------------------
    // Register file x1..x31. x0 has no storage; reads of x0 return 0.
    // -----------------------------------------------------------------------
    logic [31:0] rf_q [1:31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && (wb_dest != 5'd0)) begin
            rf_q[wb_dest] <= wb_data;
        end
    end

    // -----------------------------------------------------------------------
    // Instruction fields and sign-extended immediates.
    // -----------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    // B and J offsets are stored without bit 0 in the encoding.
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};

    // -----------------------------------------------------------------------
    // Register read with same-cycle writeback bypass. The bypass lets a
    // result written this edge be consumed by the instruction decoded on the
    // same edge, so execute never sees a stale value.
    // -----------------------------------------------------------------------
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    always_comb begin
        rs1_val = '0;
        if (rs1 != 5'd0) begin
            if (wb_en && (wb_dest == rs1)) begin
                rs1_val = wb_data;
            end else begin
                rs1_val = rf_q[rs1];
            end
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != 5'd0) begin
            if (wb_en && (wb_dest == rs2)) begin
                rs2_val = wb_data;
            end else begin
                rs2_val = rf_q[rs2];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state decode. Everything defaults to a bubble; each opcode only
    // raises the fields it uses, so unused fields stay 0.
    // -----------------------------------------------------------------------
    logic        is_store_d;
    logic        is_load_d;
    logic        is_branch_d;
    logic        is_jump_d;
    logic        is_reg_d;
    logic        is_alu_d;
    logic [31:0] operand_a_d;
    logic [31:0] operand_b_d;
    logic [31:0] branch_dest_d;
    logic [4:0]  dest_d;
    logic [2:0]  func3_d;
    logic        func7_d;
    logic [31:0] curr_pc_d;
    logic        valid_d;
    logic        illegal_d;

    always_comb begin
        is_store_d    = 1'b0;
        is_load_d     = 1'b0;
        is_branch_d   = 1'b0;
        is_jump_d     = 1'b0;
        is_reg_d      = 1'b0;
        is_alu_d      = 1'b0;
        operand_a_d   = '0;
        operand_b_d   = '0;
        branch_dest_d = '0;
        dest_d        = '0;
        func3_d       = '0;
        func7_d       = 1'b0;
        curr_pc_d     = '0;
        valid_d       = 1'b0;
        illegal_d     = 1'b0;

        if (instr_valid) begin
            // Common to every recognised opcode; cleared again below for
            // an unknown opcode so that case stays a pure bubble.
            curr_pc_d = pc_i;
            valid_d   = 1'b1;
            func3_d   = f3;

            case (opcode)
                OPC_OP: begin
                    is_alu_d    = 1'b1;
                    is_reg_d    = 1'b1;
                    operand_a_d = rs1_val;
                    operand_b_d = rs2_val;
                    dest_d      = rd;
                    func7_d     = instr[30];
                end
                OPC_OP_IMM: begin
                    is_alu_d    = 1'b1;
                    operand_a_d = rs1_val;
                    operand_b_d = imm_i;
                    dest_d      = rd;
                    // Only SRLI/SRAI use instr[30]; for other I-type ALU ops
                    // it is an immediate bit and must not leak into func7.
                    func7_d     = (f3 == 3'b101) ? instr[30] : 1'b0;
                end
                OPC_LUI: begin
                    is_alu_d    = 1'b1;
                    operand_b_d = imm_u;
                    dest_d      = rd;
                    func3_d     = 3'b000;
                end
                OPC_AUIPC: begin
                    is_alu_d    = 1'b1;
                    operand_a_d = pc_i;
                    operand_b_d = imm_u;
                    dest_d      = rd;
                    func3_d     = 3'b000;
                end
                OPC_LOAD: begin
                    is_load_d     = 1'b1;
                    operand_a_d   = rs1_val;
                    branch_dest_d = imm_i;
                    dest_d        = rd;
                end
                OPC_STORE: begin
                    is_store_d    = 1'b1;
                    operand_a_d   = rs1_val;
                    operand_b_d   = rs2_val;
                    branch_dest_d = imm_s;
                end
                OPC_BRANCH: begin
                    is_branch_d   = 1'b1;
                    operand_a_d   = rs1_val;
                    operand_b_d   = rs2_val;
                    branch_dest_d = imm_b;
                end
                OPC_JAL: begin
                    is_jump_d     = 1'b1;
                    branch_dest_d = imm_j;
                    dest_d        = rd;
                end
                OPC_JALR: begin
                    is_jump_d     = 1'b1;
                    operand_a_d   = rs1_val;
                    branch_dest_d = imm_i;
                    dest_d        = rd;
                end
                default: begin
                    curr_pc_d = '0;
                    valid_d   = 1'b0;
                    func3_d   = '0;
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output registers. stall freezes the whole bundle; reset wins over
    // stall so a reset taken mid-stall leaves outputs at 0 until the next
    // accepted decode.
    // -----------------------------------------------------------------------
    logic        is_store_q;
    logic        is_load_q;
    logic        is_branch_q;
    logic        is_jump_q;
    logic        is_reg_q;
    logic        is_alu_q;
    logic [31:0] operand_a_q;
    logic [31:0] operand_b_q;
    logic [31:0] branch_dest_q;
    logic [4:0]  dest_q;
    logic [2:0]  func3_q;
    logic        func7_q;
    logic [31:0] curr_pc_q;
    logic        valid_q;
    logic        illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_store_q    <= 1'b0;
            is_load_q     <= 1'b0;
            is_branch_q   <= 1'b0;
            is_jump_q     <= 1'b0;
            is_reg_q      <= 1'b0;
            is_alu_q      <= 1'b0;
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            branch_dest_q <= '0;
            dest_q        <= '0;
            func3_q       <= '0;
            func7_q       <= 1'b0;
            curr_pc_q     <= '0;
            valid_q       <= 1'b0;
            illegal_q     <= 1'b0;
        end else if (!stall) begin
            is_store_q    <= is_store_d;
            is_load_q     <= is_load_d;
            is_branch_q   <= is_branch_d;
            is_jump_q     <= is_jump_d;
            is_reg_q      <= is_reg_d;
            is_alu_q      <= is_alu_d;
            operand_a_q   <= operand_a_d;
            operand_b_q   <= operand_b_d;
            branch_dest_q <= branch_dest_d;
            dest_q        <= dest_d;
            func3_q       <= func3_d;
            func7_q       <= func7_d;
            curr_pc_q     <= curr_pc_d;
            valid_q       <= valid_d;
            illegal_q     <= illegal_d;
        end
    end

    assign is_store    = is_store_q;
    assign is_load     = is_load_q;
    assign is_branch   = is_branch_q;
    assign is_jump     = is_jump_q;
    assign is_reg      = is_reg_q;
    assign is_alu      = is_alu_q;
    assign operand_a   = operand_a_q;
    assign operand_b   = operand_b_q;
    assign branch_dest = branch_dest_q;
    assign dest_o      = dest_q;
    assign func3       = func3_q;
    assign func7       = func7_q;
    assign curr_pc     = curr_pc_q;
    assign valid_o     = valid_q;
    assign illegal     = illegal_q;

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising-edge active.
REQ-002 SHALL have reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have instr  in  32  RV32I instruction word.
REQ-004 SHALL have instr_valid  in  1  instr and pc_i are valid this cycle.
REQ-005 SHALL have pc_i  in  32  PC of instr.
REQ-006 SHALL have stall  in  1  downstream not ready; hold all outputs.
REQ-007 SHALL have wb_en  in  1, wb_dest  in  5, wb_data  in  32: register-file write port, fed from execute result/dest_o.
REQ-008 SHALL have outputs is_store, is_load, is_branch, is_jump, is_reg, is_alu  out  1 each: instruction class flags to execute.
REQ-009 SHALL have operand_a  out  32, operand_b  out  32, branch_dest  out  32: operands and PC-relative or base offset.
REQ-010 SHALL have dest_o  out  5, func3  out  3, func7  out  1, curr_pc  out  32, valid_o  out  1, illegal  out  1.

Function
REQ-011 SHALL contain 31 x 32-bit registers x1..x31; x0 reads 0; writes to x0 are dropped.
REQ-012 SHALL write wb_data to wb_dest on the rising edge when wb_en=1, including during stall.
REQ-013 SHALL bypass: a read of register r in the same cycle as a write to r (r!=0) returns wb_data.
REQ-014 SHALL register all outputs; latency instr -> outputs is one clock.
REQ-015 SHALL, when stall=1, hold every output and ignore instr/instr_valid.
REQ-016 SHALL, when stall=0 and instr_valid=0, issue a bubble: all flags 0, dest_o 0, valid_o 0, illegal 0.
REQ-017 SHALL decode opcodes as follows; unused fields are 0:
  - OP 0110011: is_alu=1, is_reg=1; a=rs1, b=rs2; func7=instr[30].
  - OP-IMM 0010011: is_alu=1; a=rs1, b=I-imm; func7=instr[30] only when func3=101, else 0.
  - LUI: is_alu=1; func3=000; a=0, b=U-imm.
  - AUIPC: is_alu=1; func3=000; a=pc_i, b=U-imm.
  - LOAD: is_load=1; a=rs1; branch_dest=I-imm.
  - STORE: is_store=1; a=rs1, b=rs2; branch_dest=S-imm; dest_o=0.
  - BRANCH: is_branch=1; a=rs1, b=rs2; branch_dest=B-imm; dest_o=0.
  - JAL: is_jump=1; a=0; branch_dest=J-imm.
  - JALR: is_jump=1; a=rs1; branch_dest=I-imm.
REQ-018 SHALL sign-extend all immediates to 32 bits; B/J immediates include implicit bit0=0.
REQ-019 SHALL drive dest_o=rd for OP, OP-IMM, LUI, AUIPC, LOAD, JAL and JALR; func3=instr[14:12] unless REQ-017 overrides it.
REQ-020 SHALL drive curr_pc=pc_i and valid_o=1 for every decoded instruction.
REQ-021 SHALL, on an unknown opcode (valid, not stalled), issue a bubble with illegal=1 for that one output cycle.

Reset
REQ-022 SHALL, while reset=1, force all outputs to 0 and all registers x1..x31 to 0, regardless of clk or stall.
REQ-023 SHALL, on reset asserted mid-stall, exit reset with stall state irrelevant and outputs 0 until the first valid decode.

Verification
REQ-024 Reset: assert reset with outputs nonzero -> all outputs 0 without a clock edge; x5 reads 0 afterwards.
REQ-025 Writeback + OP: wb x1=200, x2=200; decode add x3,x1,x2 -> next cycle is_alu=1, is_reg=1, a=200, b=200, dest_o=3, func7=0.
REQ-026 Branch: x1=100, x2=-300; decode blt x1,x2,+20 at pc 40 -> is_branch=1, func3=100, a=100, b=0xFFFFFED4, branch_dest=20, dest_o=0, curr_pc=40.
REQ-027 Bypass: wb x7=0x1234 in the same cycle as decoding addi x8,x7,-1 -> a=0x1234, b=0xFFFFFFFF, dest_o=8, func7=0.
REQ-028 Stall/bubble: stall=1 for 3 cycles while instr changes -> outputs unchanged; then stall=0, instr_valid=0 -> valid_o=0 and all flags 0.
REQ-029 x0 and illegal: wb x0=55, decode add x4,x0,x0 -> a=0, b=0; decode opcode 1111111 -> illegal=1, valid_o=0 for one cycle.
